// File: rtl/disp_ctrl_pkg.sv
// Shared types and constants for the display mode controller.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package disp_ctrl_pkg;

    // Display owner; the encoding is exported directly on o_mode.
    typedef enum logic [1:0] {
        MODE_TIME  = 2'd0,
        MODE_ALARM = 2'd1,
        MODE_SW    = 2'd2,
        MODE_RING  = 2'd3
    } mode_e;

    // Field currently under edit.
    typedef enum logic [1:0] {
        EDIT_NONE = 2'd0,
        EDIT_SEC  = 2'd1,
        EDIT_MIN  = 2'd2,
        EDIT_HOUR = 2'd3
    } edit_e;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } phase_e;

    // Two digits (14 bits) per field, seconds at the low end.
    localparam int FIELD_SEC_LO  = 0;
    localparam int FIELD_SEC_HI  = 13;
    localparam int FIELD_MIN_LO  = 14;
    localparam int FIELD_MIN_HI  = 27;
    localparam int FIELD_HOUR_LO = 28;
    localparam int FIELD_HOUR_HI = 41;

    localparam logic [6:0] BLANK_SEG_DEFAULT = 7'b0000000;

    typedef struct packed {
        logic [41:0] seg;
        logic [5:0]  dp;
    } img_t;

    // Blank the two digits of the selected field and clear their points.
    function automatic img_t blank_field(input img_t img, input logic [1:0] pos,
                                         input logic [6:0] blank);
        img_t r;
        r = img;
        case (edit_e'(pos))
            EDIT_SEC: begin
                r.seg[FIELD_SEC_HI:FIELD_SEC_LO] = {2{blank}};
                r.dp[1:0] = 2'b00;
            end
            EDIT_MIN: begin
                r.seg[FIELD_MIN_HI:FIELD_MIN_LO] = {2{blank}};
                r.dp[3:2] = 2'b00;
            end
            EDIT_HOUR: begin
                r.seg[FIELD_HOUR_HI:FIELD_HOUR_LO] = {2{blank}};
                r.dp[5:4] = 2'b00;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator: ON/OFF halves of BLINK_HALF cycles each, restartable.
// Latency: phase updates on the edge after restart_i/wrap; restart forces count 0, phase ON.
// Backpressure: none. Ports: clk, rst (sync, active-high), restart_i, phase_o.
module blink_timer
    import disp_ctrl_pkg::*;
#(
    parameter int BLINK_HALF = 25000000
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   restart_i,
    output phase_e phase_o
);

    localparam int CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = PHASE_ON;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= PHASE_ON;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display owner select (time/alarm/stopwatch/ring) with field blink and ring flash for led_disp.
// Latency: image, dp and o_ring_active registered 1 cycle after state/inputs; o_mode is the state register.
// Backpressure: none. Inputs: mode button, edit position, three images, ring/ack. Outputs: image, dp, mode, ring flag.
module disp_mode_ctrl
    import disp_ctrl_pkg::*;
#(
    parameter int         BLINK_HALF = 25000000,
    parameter logic [6:0] BLANK_SEG  = BLANK_SEG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mode_btn,
    input  logic [1:0]  i_edit_pos,
    input  logic [41:0] i_time_seg,
    input  logic [5:0]  i_time_dp,
    input  logic [41:0] i_alarm_seg,
    input  logic [5:0]  i_alarm_dp,
    input  logic [41:0] i_sw_seg,
    input  logic [5:0]  i_sw_dp,
    input  logic        i_ring,
    input  logic        i_ring_ack,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp,
    output logic [1:0]  o_mode,
    output logic        o_ring_active
);

    mode_e      state_q, state_d;
    mode_e      saved_q, saved_d;
    logic       ack_hold_q, ack_hold_d;
    logic [1:0] edit_q;
    img_t       img_q, img_d;
    logic       ring_q;

    logic       edit_chg;
    logic       restart;
    phase_e     phase;

    assign edit_chg = (i_edit_pos != edit_q);
    assign restart  = (state_d != state_q) || edit_chg;

    blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .phase_o   (phase)
    );

    // Mode FSM: ring preempts, ack suppresses re-entry until the ring drops.
    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        ack_hold_d = ack_hold_q;
        if (state_q == MODE_RING) begin
            if (i_ring_ack) begin
                state_d    = saved_q;
                ack_hold_d = 1'b1;
            end else if (!i_ring) begin
                state_d = saved_q;
            end
        end else if (i_ring && !ack_hold_q) begin
            state_d = MODE_RING;
            saved_d = state_q;
        end else if (i_mode_btn) begin
            case (state_q)
                MODE_TIME:  state_d = MODE_ALARM;
                MODE_ALARM: state_d = MODE_SW;
                default:    state_d = MODE_TIME;
            endcase
        end
        // A dropped ring always re-arms entry, even if acked in the same cycle.
        if (!i_ring) begin
            ack_hold_d = 1'b0;
        end
    end

    // Output image. On the cycle the edit position changes the blink phase
    // is about to restart ON, so the new field is shown unblanked at once.
    always_comb begin
        img_d = '{seg: i_time_seg, dp: i_time_dp};
        case (state_q)
            MODE_TIME, MODE_ALARM: begin
                if (state_q == MODE_ALARM) begin
                    img_d = '{seg: i_alarm_seg, dp: i_alarm_dp};
                end
                if (phase == PHASE_OFF && !edit_chg) begin
                    img_d = blank_field(img_d, i_edit_pos, BLANK_SEG);
                end
            end
            MODE_SW: begin
                img_d = '{seg: i_sw_seg, dp: i_sw_dp};
            end
            default: begin
                if (phase == PHASE_OFF) begin
                    img_d = '{seg: {6{BLANK_SEG}}, dp: 6'b000000};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MODE_TIME;
            saved_q    <= MODE_TIME;
            ack_hold_q <= 1'b0;
            edit_q     <= 2'b00;
            img_q      <= '{seg: {6{BLANK_SEG}}, dp: 6'b000000};
            ring_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            ack_hold_q <= ack_hold_d;
            edit_q     <= i_edit_pos;
            img_q      <= img_d;
            ring_q     <= (state_q == MODE_RING);
        end
    end

    assign o_six_digit_seg = img_q.seg;
    assign o_six_dp        = img_q.dp;
    assign o_mode          = state_q;
    assign o_ring_active   = ring_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Bench for disp_mode_ctrl: directed stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares.
// Latency: n/a. Backpressure: n/a.
module tb_disp_mode_ctrl;

    localparam logic [41:0] T     = {7'h16, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11};
    localparam logic [5:0]  TDP   = 6'b101010;
    localparam logic [41:0] A     = {7'h26, 7'h25, 7'h24, 7'h23, 7'h22, 7'h21};
    localparam logic [5:0]  ADP   = 6'b010101;
    localparam logic [41:0] S     = {7'h36, 7'h35, 7'h34, 7'h33, 7'h32, 7'h31};
    localparam logic [5:0]  SDP   = 6'b111000;
    localparam logic [41:0] TMIN  = {7'h16, 7'h15, 7'h00, 7'h00, 7'h12, 7'h11};
    localparam logic [5:0]  TMDP  = 6'b100010;
    localparam logic [41:0] THR   = {7'h00, 7'h00, 7'h14, 7'h13, 7'h12, 7'h11};
    localparam logic [5:0]  THDP  = 6'b001010;
    localparam logic [41:0] BLK   = 42'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mode_btn;
    logic [1:0]  i_edit_pos;
    logic [41:0] i_time_seg, i_alarm_seg, i_sw_seg;
    logic [5:0]  i_time_dp, i_alarm_dp, i_sw_dp;
    logic        i_ring, i_ring_ack;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic [1:0]  o_mode;
    logic        o_ring_active;

    disp_mode_ctrl #(.BLINK_HALF(4), .BLANK_SEG(7'b0000000)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_mode_btn      (i_mode_btn),
        .i_edit_pos      (i_edit_pos),
        .i_time_seg      (i_time_seg),
        .i_time_dp       (i_time_dp),
        .i_alarm_seg     (i_alarm_seg),
        .i_alarm_dp      (i_alarm_dp),
        .i_sw_seg        (i_sw_seg),
        .i_sw_dp         (i_sw_dp),
        .i_ring          (i_ring),
        .i_ring_ack      (i_ring_ack),
        .o_six_digit_seg (o_six_digit_seg),
        .o_six_dp        (o_six_dp),
        .o_mode          (o_mode),
        .o_ring_active   (o_ring_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [41:0] seg;
        logic [5:0]  dp;
        logic [1:0]  mode;
        logic        ring;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expectation for the outputs as they stand after the edge just taken.
    task automatic push_exp(input string nm, input logic [41:0] s, input logic [5:0] d,
                            input logic [1:0] m, input logic r);
        exp_t e;
        e.cyc  = cyc;
        e.seg  = s;
        e.dp   = d;
        e.mode = m;
        e.ring = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    exp_t  me;
    string mnm;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            me  = exp_q.pop_front();
            mnm = name_q.pop_front();
            total++;
            if (me.cyc != cyc) begin
                bad++;
                $display("FAIL %s: slot cycle %0d never checked (now %0d)", mnm, me.cyc, cyc);
            end else if (o_six_digit_seg !== me.seg || o_six_dp !== me.dp ||
                         o_mode !== me.mode || o_ring_active !== me.ring) begin
                bad++;
                $display("FAIL %s cyc=%0d: got seg=%h dp=%b mode=%0d ring=%b, want seg=%h dp=%b mode=%0d ring=%b",
                         mnm, cyc, o_six_digit_seg, o_six_dp, o_mode, o_ring_active,
                         me.seg, me.dp, me.mode, me.ring);
            end
        end
    end

    initial begin
        rst = 1'b1; i_mode_btn = 1'b0; i_edit_pos = 2'd0;
        i_time_seg = T; i_time_dp = TDP; i_alarm_seg = A; i_alarm_dp = ADP;
        i_sw_seg = S; i_sw_dp = SDP; i_ring = 1'b0; i_ring_ack = 1'b0;

        // Reset and mode cycling.
        tick(); push_exp("reset", BLK, 6'd0, 2'd0, 1'b0);
        rst = 1'b0;
        tick(); push_exp("time0", T, TDP, 2'd0, 1'b0);
        i_mode_btn = 1'b1; tick(); push_exp("to_alarm", T, TDP, 2'd1, 1'b0);
        i_mode_btn = 1'b0; tick(); push_exp("alarm_img", A, ADP, 2'd1, 1'b0);
        i_mode_btn = 1'b1; tick(); push_exp("to_sw", A, ADP, 2'd2, 1'b0);
        i_mode_btn = 1'b0; tick(); push_exp("sw_img", S, SDP, 2'd2, 1'b0);
        i_mode_btn = 1'b1; tick(); push_exp("to_time", S, SDP, 2'd0, 1'b0);
        i_mode_btn = 1'b0; tick(); push_exp("time_img", T, TDP, 2'd0, 1'b0);

        // Minute field blink, then switch to hour mid-OFF.
        i_edit_pos = 2'd2;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i >= 5) push_exp("blink_min", TMIN, TMDP, 2'd0, 1'b0);
            else        push_exp("blink_min", T, TDP, 2'd0, 1'b0);
        end
        i_edit_pos = 2'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 5 && i <= 8) push_exp("blink_hour", THR, THDP, 2'd0, 1'b0);
            else                  push_exp("blink_hour", T, TDP, 2'd0, 1'b0);
        end

        // Stopwatch ignores edit position.
        i_edit_pos = 2'd1; i_mode_btn = 1'b1;
        tick(); push_exp("sw_path_t", T, TDP, 2'd1, 1'b0);
        tick(); push_exp("sw_path_a", A, ADP, 2'd2, 1'b0);
        i_mode_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(); push_exp("sw_noblink", S, SDP, 2'd2, 1'b0);
        end

        // Back to ALARM, then ring with a simultaneous button press.
        i_mode_btn = 1'b1; tick(); tick();
        i_mode_btn = 1'b0; i_edit_pos = 2'd0;
        tick(); push_exp("alarm_again", A, ADP, 2'd1, 1'b0);
        i_ring = 1'b1; i_mode_btn = 1'b1;
        tick(); push_exp("ring_enter", A, ADP, 2'd3, 1'b0);
        i_mode_btn = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i >= 4 && i <= 7) push_exp("ring_flash", BLK, 6'd0, 2'd3, 1'b1);
            else                  push_exp("ring_flash", T, TDP, 2'd3, 1'b1);
        end
        i_ring = 1'b0;
        tick(); push_exp("ring_exit", T, TDP, 2'd1, 1'b1);
        tick(); push_exp("ring_saved", A, ADP, 2'd1, 1'b0);

        // Acknowledge holds off re-entry until the ring drops.
        i_ring = 1'b1;
        tick(); push_exp("ring2_enter", A, ADP, 2'd3, 1'b0);
        tick(); push_exp("ring2_on", T, TDP, 2'd3, 1'b1);
        i_ring_ack = 1'b1;
        tick(); push_exp("ack_exit", T, TDP, 2'd1, 1'b1);
        i_ring_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); push_exp("ack_hold", A, ADP, 2'd1, 1'b0);
        end
        i_ring = 1'b0;
        tick(); push_exp("ring_drop", A, ADP, 2'd1, 1'b0);
        i_ring = 1'b1;
        tick(); push_exp("ring3_enter", A, ADP, 2'd3, 1'b0);
        tick(); push_exp("ring3_on", T, TDP, 2'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) push_exp("ring3_off", BLK, 6'd0, 2'd3, 1'b1);
            else        push_exp("ring3_on", T, TDP, 2'd3, 1'b1);
        end

        // Reset during the OFF phase of a ring.
        rst = 1'b1;
        tick(); push_exp("mid_reset", BLK, 6'd0, 2'd0, 1'b0);
        rst = 1'b0; i_ring = 1'b0;
        tick(); push_exp("post_reset", T, TDP, 2'd0, 1'b0);

        tick(); tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_mode_ctrl.md
Name: disp_mode_ctrl

Overview:
- Selects which 42-bit segment image (time, alarm setting, stopwatch) is presented to the 6-digit multiplexed LED driver, and applies field-blink and alarm-ring flashing.
- Sits between the clock/alarm/stopwatch datapaths and led_disp. Its outputs connect directly to led_disp's i_six_digit_seg and i_six_dp.
- A mode button cycles the owner. A ringing alarm preempts any mode.

Parameters:
- BLINK_HALF, 25000000: clk cycles per blink half-period (on or off); minimum 2.
- BLANK_SEG, 7'b0000000: segment pattern for an unlit digit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_mode_btn  in  1  one-cycle pulse; advance display mode
- i_edit_pos  in  2  0=none, 1=sec field, 2=min field, 3=hour field under edit
- i_time_seg  in  42  time image, digit0 (sec-right) at [6:0] … digit5 at [41:35]
- i_time_dp  in  6  time decimal points, bit n = digit n
- i_alarm_seg  in  42  alarm-setting image
- i_alarm_dp  in  6  alarm decimal points
- i_sw_seg  in  42  stopwatch image
- i_sw_dp  in  6  stopwatch decimal points
- i_ring  in  1  level; alarm is ringing
- i_ring_ack  in  1  one-cycle pulse; user silences ring display
- o_six_digit_seg  out  42  registered image to led_disp
- o_six_dp  out  6  registered decimal points to led_disp
- o_mode  out  2  current state encoding
- o_ring_active  out  1  high while in RING

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high; everything samples on the rising edge of clk.
- Reset values:
  - state = TIME; saved_mode = TIME; ack_hold = 0
  - blink counter = 0; phase = ON
  - o_six_digit_seg = {6{BLANK_SEG}}; o_six_dp = 0; o_mode = 0; o_ring_active = 0
- State encodings: TIME=0, ALARM=1, SW=2, RING=3. o_mode equals the state register.
- Transitions, in priority order, evaluated each cycle:
  1. Entering RING: from any non-RING state, if i_ring=1 and ack_hold=0, go to RING and set saved_mode = current state. i_mode_btn in the same cycle is discarded.
  2. Leaving RING: if i_ring_ack=1, go to saved_mode and set ack_hold=1. If instead i_ring=0, go to saved_mode and leave ack_hold unchanged. i_mode_btn is ignored while in RING.
  3. Mode cycling: in a non-RING state, i_mode_btn=1 advances TIME→ALARM→SW→TIME.
  4. ack_hold clears on any cycle where i_ring=0. A continuing ring therefore cannot re-enter RING after acknowledgement.
- Blink timer:
  - The counter counts 0..BLINK_HALF-1. On wrap it returns to 0 and phase toggles.
  - Counter and phase restart (0, ON) on any cycle where the state changes or i_edit_pos changes. This makes a newly edited field visible immediately.
- Output image, registered with exactly 1 cycle latency from inputs and state:
  - TIME: i_time_seg/dp.
  - ALARM: i_alarm_seg/dp.
  - In TIME or ALARM with i_edit_pos≠0 and phase=OFF, the selected field is blanked:
    - pos1 → digits 1:0
    - pos2 → digits 3:2
    - pos3 → digits 5:4
    - Each blanked digit gets BLANK_SEG and its dp forced to 0.
  - SW: i_sw_seg/dp; i_edit_pos is ignored.
  - RING: i_time_seg/dp. When phase=OFF, all six digits are blanked and all dp are 0.
- o_ring_active is registered and equals (state==RING) with the same 1-cycle latency as the image.
- Reset mid-operation: state, timer and outputs return to their reset values on the next edge, regardless of ring or button activity.

Decomposition:
- Package disp_ctrl_pkg holds:
  - mode encodings (TIME/ALARM/SW/RING)
  - edit-position codes
  - field slice constants (FIELD_SEC = [13:0], FIELD_MIN = [27:14], FIELD_HOUR = [41:28])
  - default BLANK_SEG
- Sub-module blink_timer (parameter BLINK_HALF):
  - inputs: clk, rst, restart
  - output: phase
- The FSM and output mux stay in disp_mode_ctrl.

Test Plan:
- Reset, then 3 i_mode_btn pulses with distinct images → o_mode goes 0→1→2→0; o_six_digit_seg shows each image 1 cycle after its state change; after reset the output is all BLANK_SEG.
- BLINK_HALF=4, TIME mode, i_edit_pos=2 → digits 3:2 (bits [27:14]) alternate between time value and BLANK_SEG every 4 cycles with dp[3:2]=0 when blank; changing i_edit_pos to 3 restarts phase ON and blinks [41:28] instead.
- In SW with i_edit_pos=1 → image is never blanked.
- In ALARM, assert i_ring with i_mode_btn in the same cycle → state RING (o_mode=3, o_ring_active=1); whole time image flashes at BLINK_HALF; deassert i_ring → returns to ALARM, not SW.
- In RING, pulse i_ring_ack with i_ring held high → returns to saved mode and stays there while i_ring=1; drop i_ring 1 cycle, reassert → re-enters RING.
- Assert rst mid-RING during the OFF phase → next cycle state=TIME, o_mode=0, outputs blank, o_ring_active=0.
